banco_registros_param: RTL and testbench

Parametrised successor to the 8x8 register bank. It has two independent combinational read ports and one write port with its own address, and an optional write-through bypass. An optional hardwired-zero R0 is available, plus a single-cycle shadow bank for save/restore around interrupts. A sequential clear engine zeroes the main bank one register per cycle. It sits between the decoder/control unit and the ALU operand muxes of the next MicroUAZ datapath.

---
 rtl/banco_registros_param_if.sv | 30 +++
 rtl/banco_registros_param.sv | 119 +++++++++++
 tb/tb_banco_registros_param.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_registros_param_if.sv
// Bus bundle for banco_registros_param: read/write addresses, write data,
// bank control strobes and the read results.
interface banco_registros_param_if #(
    parameter int W    = 8,
    parameter int NREG = 8
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [AW-1:0] SelX;
    logic [AW-1:0] SelY;
    logic [AW-1:0] SelW;
    logic          We;
    logic [W-1:0]  Dw;
    logic          Save;
    logic          Restore;
    logic          Clr;
    logic [W-1:0]  Rx;
    logic [W-1:0]  Ry;
    logic          Busy;

    modport master (
        output SelX, SelY, SelW, We, Dw, Save, Restore, Clr,
        input  Rx, Ry, Busy
    );

    modport slave (
        input  SelX, SelY, SelW, We, Dw, Save, Restore, Clr,
        output Rx, Ry, Busy
    );
endinterface

// File: rtl/banco_registros_param.sv
// Parametrised register bank: two combinational read ports, one write port,
// optional write-through bypass, optional zero R0, shadow bank and clear engine.
module banco_registros_param #(
    parameter int W       = 8,
    parameter int NREG    = 8,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input logic                    Clk,
    input logic                    Rst_n,
    banco_registros_param_if.slave bus
);
    localparam int                AW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [AW:0]       NREG_L = (AW+1)'(NREG);
    localparam logic [AW-1:0]     LAST   = AW'(NREG - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  main_q   [NREG];
    logic [W-1:0]  shadow_q [NREG];

    logic do_write, do_save, do_restore, do_clear;
    logic [W-1:0] rx, ry;

    // An address is live only inside the bank and, with ZERO_R0, not at 0.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_L) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        do_write   = 1'b0;
        do_save    = 1'b0;
        do_restore = 1'b0;
        do_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (bus.Restore) begin
                    do_restore = 1'b1;
                end else begin
                    do_save  = bus.Save;
                    do_write = bus.We && addr_live(bus.SelW);
                end
            end
            CLEAR: begin
                do_clear = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: the banks are flop arrays, not RAM, so they are reset like any register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) main_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (do_restore)
                    main_q[i] <= shadow_q[i];
                else if (do_clear && (cnt == AW'(i)))
                    main_q[i] <= '0;
                else if (do_write && (bus.SelW == AW'(i)))
                    main_q[i] <= bus.Dw;
            end
        end
    end

    // Save samples the pre-edge main bank, so a same-cycle write misses the shadow.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else if (do_save) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= main_q[i];
        end
    end

    function automatic logic [W-1:0] read_port(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++)
            if (a == AW'(i)) v = main_q[i];
        if (!addr_live(a))
            v = '0;
        if ((BYPASS != 0) && do_write && (bus.SelW == a))
            v = bus.Dw;
        return v;
    endfunction

    always_comb rx = read_port(bus.SelX);
    always_comb ry = read_port(bus.SelY);

    assign bus.Rx   = rx;
    assign bus.Ry   = ry;
    assign bus.Busy = (state == CLEAR);
endmodule

// File: tb/tb_banco_registros_param.sv
// Self-checking bench: three builds of the bank share one stimulus stream and
// are compared each cycle against an array-based reference model.
module tb_banco_registros_param;
    localparam int ND = 3;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic [4:0]  sel_x, sel_y, sel_w;
    logic        we, save, restore, clr;
    logic [15:0] dw;

    banco_registros_param_if #(.W(8),  .NREG(8))  bus_a ();
    banco_registros_param_if #(.W(8),  .NREG(6))  bus_b ();
    banco_registros_param_if #(.W(16), .NREG(32)) bus_c ();

    assign bus_a.SelX = sel_x[2:0]; assign bus_a.SelY = sel_y[2:0]; assign bus_a.SelW = sel_w[2:0];
    assign bus_b.SelX = sel_x[2:0]; assign bus_b.SelY = sel_y[2:0]; assign bus_b.SelW = sel_w[2:0];
    assign bus_c.SelX = sel_x;      assign bus_c.SelY = sel_y;      assign bus_c.SelW = sel_w;
    assign bus_a.Dw = dw[7:0]; assign bus_b.Dw = dw[7:0]; assign bus_c.Dw = dw;
    assign bus_a.We = we; assign bus_b.We = we; assign bus_c.We = we;
    assign bus_a.Save = save; assign bus_b.Save = save; assign bus_c.Save = save;
    assign bus_a.Restore = restore; assign bus_b.Restore = restore; assign bus_c.Restore = restore;
    assign bus_a.Clr = clr; assign bus_b.Clr = clr; assign bus_c.Clr = clr;

    banco_registros_param #(.W(8), .NREG(8), .BYPASS(1), .ZERO_R0(0))
        dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_a));
    banco_registros_param #(.W(8), .NREG(6), .BYPASS(0), .ZERO_R0(1))
        dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_b));
    banco_registros_param #(.W(16), .NREG(32), .BYPASS(1), .ZERO_R0(0))
        dut_c (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_c));

    logic [15:0] rx_o [ND];
    logic [15:0] ry_o [ND];
    logic        busy_o [ND];
    assign rx_o[0] = {8'h00, bus_a.Rx}; assign ry_o[0] = {8'h00, bus_a.Ry}; assign busy_o[0] = bus_a.Busy;
    assign rx_o[1] = {8'h00, bus_b.Rx}; assign ry_o[1] = {8'h00, bus_b.Ry}; assign busy_o[1] = bus_b.Busy;
    assign rx_o[2] = bus_c.Rx;          assign ry_o[2] = bus_c.Ry;          assign busy_o[2] = bus_c.Busy;

    // Build configurations, mirrored from the instance parameters above.
    int cfg_w   [ND] = '{8, 8, 16};
    int cfg_n   [ND] = '{8, 6, 32};
    int cfg_aw  [ND] = '{3, 3, 5};
    int cfg_byp [ND] = '{1, 0, 1};
    int cfg_z0  [ND] = '{0, 1, 0};

    int unsigned m_main   [ND][32];
    int unsigned m_shadow [ND][32];
    bit          m_busy   [ND];
    int          m_cnt    [ND];

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt [ND];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned addr_of(int d, logic [4:0] s);
        return int'(s) % (1 << cfg_aw[d]);
    endfunction

    function automatic bit live(int d, int unsigned a);
        return (a < cfg_n[d]) && !(cfg_z0[d] != 0 && a == 0);
    endfunction

    function automatic int unsigned fit(int d, int unsigned v);
        return v & ((1 << cfg_w[d]) - 1);
    endfunction

    function automatic int unsigned exp_read(int d, logic [4:0] s);
        int unsigned a;
        a = addr_of(d, s);
        if (!live(d, a)) return 0;
        if (cfg_byp[d] != 0 && !m_busy[d] && we && !clr && !restore && addr_of(d, sel_w) == a)
            return fit(d, dw);
        return m_main[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_main[d][i]   = 0;
                m_shadow[d][i] = 0;
            end
            m_busy[d] = 0;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic model_edge();
        int unsigned a;
        for (int d = 0; d < ND; d++) begin
            if (m_busy[d]) begin
                m_main[d][m_cnt[d]] = 0;
                if (m_cnt[d] == cfg_n[d] - 1) m_busy[d] = 0;
                else m_cnt[d]++;
            end else if (clr) begin
                m_busy[d] = 1;
                m_cnt[d]  = 0;
            end else if (restore) begin
                for (int i = 0; i < cfg_n[d]; i++) m_main[d][i] = m_shadow[d][i];
            end else begin
                if (save)
                    for (int i = 0; i < cfg_n[d]; i++) m_shadow[d][i] = m_main[d][i];
                a = addr_of(d, sel_w);
                if (we && live(d, a)) m_main[d][a] = fit(d, dw);
            end
        end
    endtask

    task automatic step_begin();
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rx[%0d]", d), rx_o[d], exp_read(d, sel_x));
            check($sformatf("ry[%0d]", d), ry_o[d], exp_read(d, sel_y));
            check($sformatf("busy[%0d]", d), busy_o[d], m_busy[d]);
        end
    endtask

    task automatic step_end();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    task automatic cyc();
        step_begin();
        step_end();
    endtask

    task automatic idle();
        we = 0; save = 0; restore = 0; clr = 0;
    endtask

    task automatic write(input logic [4:0] a, input logic [15:0] v);
        sel_w = a; dw = v; we = 1;
        cyc();
        we = 0;
    endtask

    initial begin
        Rst_n = 0;
        idle();
        sel_x = 0; sel_y = 0; sel_w = 0; dw = 0;
        model_reset();
        @(negedge Clk);
        step_begin();
        for (int d = 0; d < ND; d++) check($sformatf("rst_rx[%0d]", d), rx_o[d], 0);
        Rst_n = 1;
        step_end();

        // Writes, with and without bypass in the write cycle.
        sel_x = 3; sel_y = 5; sel_w = 3; dw = 16'h00A5; we = 1;
        step_begin();
        check("t1_bypass_a", rx_o[0], 16'h00A5);
        check("t1_nobypass_b", rx_o[1], 16'h0000);
        step_end();
        sel_w = 5; dw = 16'h003C;
        cyc();
        we = 0;
        step_begin();
        check("t1_rx_a", rx_o[0], 16'h00A5);
        check("t1_ry_a", ry_o[0], 16'h003C);
        check("t1_rx_b", rx_o[1], 16'h00A5);
        check("t1_ry_b", ry_o[1], 16'h003C);
        step_end();

        // Zero R0 and out-of-range addresses.
        write(5'd0, 16'h00FF);
        sel_x = 0;
        step_begin();
        check("t2_r0_zero_b", rx_o[1], 16'h0000);
        check("t2_r0_a", rx_o[0], 16'h00FF);
        step_end();
        write(5'd7, 16'h0077);
        sel_x = 7; sel_y = 3;
        step_begin();
        check("t2_oob_b", rx_o[1], 16'h0000);
        check("t2_r3_kept_b", ry_o[1], 16'h00A5);
        step_end();
        for (int i = 0; i < 8; i++) begin
            sel_x = 5'(i); sel_y = 5'(7 - i);
            cyc();
        end

        // Save alongside a write, then Restore alongside a dropped write.
        write(5'd2, 16'h0011);
        sel_x = 2; sel_w = 2; dw = 16'h0022; we = 1; save = 1;
        cyc();
        idle();
        step_begin();
        check("t3_main_a", rx_o[0], 16'h0022);
        step_end();
        dw = 16'h0033; we = 1; restore = 1;
        cyc();
        idle();
        step_begin();
        check("t3_restore_a", rx_o[0], 16'h0011);
        check("t3_restore_b", rx_o[1], 16'h0011);
        step_end();

        // Clear engine: busy length per build, writes ignored while busy.
        for (int i = 0; i < 8; i++) write(5'(i), 16'(i + 1));
        clr = 1;
        cyc();
        clr = 0;
        for (int d = 0; d < ND; d++) busy_cnt[d] = 0;
        for (int c = 0; c < 40; c++) begin
            sel_x = 5'($urandom); sel_y = 5'($urandom); sel_w = 5'($urandom);
            dw = 16'($urandom); we = 1;
            step_begin();
            for (int d = 0; d < ND; d++) if (busy_o[d]) busy_cnt[d]++;
            step_end();
        end
        idle();
        check("t4_busy_len_a", busy_cnt[0], 8);
        check("t4_busy_len_b", busy_cnt[1], 6);
        check("t6_busy_len_c", busy_cnt[2], 32);
        restore = 1;
        cyc();
        restore = 0;
        for (int i = 0; i < 8; i++) begin
            sel_x = 5'(i); sel_y = 5'(i + 8);
            cyc();
        end

        // Async reset in the 4th busy cycle.
        for (int i = 1; i < 6; i++) write(5'(i), 16'(16'h40 + i));
        clr = 1;
        cyc();
        clr = 0;
        repeat (3) cyc();
        sel_x = 1; sel_y = 4;
        step_begin();
        Rst_n = 0;
        #1;
        model_reset();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("t5_busy[%0d]", d), busy_o[d], 0);
            check($sformatf("t5_rx[%0d]", d), rx_o[d], 0);
            check($sformatf("t5_ry[%0d]", d), ry_o[d], 0);
        end
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1;
        sel_x = 4;
        write(5'd4, 16'h005A);
        step_begin();
        check("t5_write_a", rx_o[0], 16'h005A);
        check("t5_write_b", rx_o[1], 16'h005A);
        step_end();

        // Wide build, top register on both ports.
        write(5'd31, 16'hBEEF);
        sel_x = 31; sel_y = 31;
        step_begin();
        check("t6_rx_c", rx_o[2], 16'hBEEF);
        check("t6_ry_c", ry_o[2], 16'hBEEF);
        step_end();

        // Random traffic.
        repeat (1500) begin
            sel_x   = 5'($urandom);
            sel_y   = 5'($urandom);
            sel_w   = 5'($urandom);
            dw      = 16'($urandom);
            we      = 1'($urandom_range(0, 1));
            save    = ($urandom_range(0, 7) == 0);
            restore = ($urandom_range(0, 9) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
